// File: rtl/draw_menu_background.sv
// Menu background: ROM grayscale image with a blinking highlight bar on the selected entry.
// Defining DRAW_MENU_DIAG_OVERLAY_EN adds a coloured hcount==vcount diagnostic diagonal.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_menu_background #(
    parameter int          IMG_W        = 400,
    parameter int          ROM_LAT      = 2,
    parameter int          PIX_BITS     = 4,
    parameter int          N_ITEMS      = 4,
    parameter int          BAR_X        = 50,
    parameter int          BAR_W        = 128,
    parameter int          BAR_Y0       = 500,
    parameter int          BAR_H        = 7,
    parameter int          BAR_PITCH    = 8,
    parameter logic [11:0] BAR_RGB      = 12'haaa,
    parameter int          BLINK_FRAMES = 16
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [`VGA_BUS_SIZE-1:0] vga_in,
    output logic [`VGA_BUS_SIZE-1:0] vga_out,
    output logic [19:0]              address,
    input  logic [PIX_BITS-1:0]      rom_pix,
    input  logic                     sel_up,
    input  logic                     sel_down,
    input  logic                     confirm,
    input  logic                     cancel,
    output logic [2:0]               selected,
    output logic                     locked,
    output logic                     mode_valid
);

    // Bus layout: {hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0]}
    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } timing_t;

    typedef enum logic {BROWSE, LOCKED} state_t;

    function automatic logic [11:0] expand_gray(input logic [PIX_BITS-1:0] pix);
        logic [3:0] g;
        g = 4'(pix) << (4 - PIX_BITS);
        return {g, g, g};
    endfunction

    function automatic logic bar_hit(input logic [10:0] hc, input logic [10:0] vc,
                                     input logic [2:0] idx);
        int top;
        top = BAR_Y0 + int'(idx) * BAR_PITCH;
        return (int'(hc) >= BAR_X) && (int'(hc) < BAR_X + BAR_W) &&
               (int'(vc) >= top) && (int'(vc) < top + BAR_H);
    endfunction

`ifdef DRAW_MENU_DIAG_OVERLAY_EN
    function automatic logic [11:0] diag_rgb(input logic [10:0] vc);
        if (vc < 11'd100)      return 12'hfff;
        else if (vc < 11'd200) return 12'h00f;
        else if (vc < 11'd300) return 12'h0f0;
        else if (vc < 11'd400) return 12'hf00;
        else if (vc < 11'd500) return 12'hf0f;
        else                   return 12'h0ff;
    endfunction
`endif

    timing_t             timing_p [ROM_LAT];
    logic [ROM_LAT-1:0]  vld_p;
    timing_t             cur_p;
    timing_t             out_t;
    logic [11:0]         pix_rgb;
    logic                vblnk_rise;
    logic [2:0]          disp_sel;
    logic [15:0]         frame_cnt;
    logic                blink_on;
    state_t              state, state_n;
    logic [2:0]          sel_n;
    logic                mv_n;
    logic                unused_in_rgb;

    assign unused_in_rgb = ^vga_in[11:0];

    assign address = 20'(vga_in[37:28]) + 20'(vga_in[24:15]) * 20'(IMG_W);

    // Stage p0..p(ROM_LAT-1): timing waits for the ROM word of the same pixel
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) timing_p[i] <= '0;
            vld_p <= '0;
        end else begin
            timing_p[0] <= vga_in[`VGA_BUS_SIZE-1:12];
            vld_p[0]    <= 1'b1;
            for (int i = 1; i < ROM_LAT; i++) begin
                timing_p[i] <= timing_p[i-1];
                vld_p[i]    <= vld_p[i-1];
            end
        end
    end

    assign cur_p      = timing_p[ROM_LAT-1];
    assign out_t      = vga_out[`VGA_BUS_SIZE-1:12];
    assign vblnk_rise = cur_p.vblnk & ~out_t.vblnk;

    always_comb begin
        pix_rgb = expand_gray(rom_pix);
        if (blink_on && bar_hit(cur_p.hcount, cur_p.vcount, disp_sel)) pix_rgb = BAR_RGB;
`ifdef DRAW_MENU_DIAG_OVERLAY_EN
        if (cur_p.hcount == cur_p.vcount) pix_rgb = diag_rgb(cur_p.vcount);
`endif
        if (cur_p.hblnk || cur_p.vblnk) pix_rgb = '0;
    end

    // Output stage: flushed stages after reset render as all-zero bus
    always_ff @(posedge pclk) begin
        if (rst)                      vga_out <= '0;
        else if (vld_p[ROM_LAT-1])    vga_out <= {cur_p, pix_rgb};
        else                          vga_out <= '0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            disp_sel  <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (vblnk_rise) disp_sel <= selected;
            if (state == LOCKED) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (vblnk_rise) begin
                if (int'(frame_cnt) == BLINK_FRAMES - 1) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= BROWSE;
            selected   <= '0;
            mode_valid <= 1'b0;
        end else begin
            state      <= state_n;
            selected   <= sel_n;
            mode_valid <= mv_n;
        end
    end

    // Confirm outranks navigation; simultaneous up/down cancel out
    always_comb begin
        state_n = state;
        sel_n   = selected;
        mv_n    = 1'b0;
        case (state)
            BROWSE: begin
                if (confirm) begin
                    state_n = LOCKED;
                    mv_n    = 1'b1;
                end else if (sel_down && !sel_up) begin
                    sel_n = (int'(selected) == N_ITEMS - 1) ? 3'd0 : selected + 3'd1;
                end else if (sel_up && !sel_down) begin
                    sel_n = (selected == 3'd0) ? 3'(N_ITEMS - 1) : selected - 3'd1;
                end
            end
            LOCKED: begin
                if (cancel) state_n = BROWSE;
            end
            default: state_n = BROWSE;
        endcase
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_draw_menu_background.sv
// Randomised bench for draw_menu_background with a cycle-indexed reference model and ROM model.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_draw_menu_background;

    localparam int ROM_LAT = 2;
    localparam int IMG_W   = 400;
    localparam int N_ITEMS = 4;
    localparam int BF      = 2;
    localparam int MAXC    = 8192;

    typedef struct {
        int hc;
        int vc;
        bit hs;
        bit vs;
        bit hb;
        bit vb;
    } pix_t;

    logic                     pclk = 1'b0;
    logic                     rst = 1'b1;
    logic [`VGA_BUS_SIZE-1:0] vga_in = '0;
    logic [`VGA_BUS_SIZE-1:0] vga_out;
    logic [19:0]              address;
    logic [3:0]               rom_pix = '0;
    logic                     sel_up = 1'b0, sel_down = 1'b0, confirm = 1'b0, cancel = 1'b0;
    logic [2:0]               selected;
    logic                     locked;
    logic                     mode_valid;

    draw_menu_background #(.ROM_LAT(ROM_LAT), .IMG_W(IMG_W), .N_ITEMS(N_ITEMS),
                           .BLINK_FRAMES(BF)) dut (
        .pclk(pclk), .rst(rst), .vga_in(vga_in), .vga_out(vga_out), .address(address),
        .rom_pix(rom_pix), .sel_up(sel_up), .sel_down(sel_down), .confirm(confirm),
        .cancel(cancel), .selected(selected), .locked(locked), .mode_valid(mode_valid));

    always #5 pclk = ~pclk;

    int          total = 0;
    int          bad = 0;
    bit          chk_en = 0;
    pix_t        hist [MAXC];
    int          cyc = 0;
    int          last_rst = 0;
    int          m_sel = 0, m_disp = 0, m_cnt = 0;
    bit          m_lock = 0, m_mv = 0, m_blink = 1;
    logic [37:0] exp_out = '0;
    logic [19:0] exp_addr = '0;
    logic [19:0] rom_hist [ROM_LAT];
    logic [19:0] poke_a = 20'd1205;
    logic [3:0]  poke_v = 4'h7;
    bit          vb_r = 0;

    function automatic logic [3:0] rom_val(input logic [19:0] a);
        if (a == poke_a) return poke_v;
        return a[3:0] ^ a[11:8] ^ a[19:16];
    endfunction

    function automatic logic [11:0] render(input pix_t p, input int disp, input bit blink);
        logic [3:0] g;
        if (p.hb || p.vb) return 12'h000;
`ifdef DRAW_MENU_DIAG_OVERLAY_EN
        if (p.hc == p.vc) begin
            if (p.vc < 100) return 12'hfff;
            if (p.vc < 200) return 12'h00f;
            if (p.vc < 300) return 12'h0f0;
            if (p.vc < 400) return 12'hf00;
            if (p.vc < 500) return 12'hf0f;
            return 12'h0ff;
        end
`endif
        if (blink && p.hc >= 50 && p.hc < 178 &&
            p.vc >= 500 + disp * 8 && p.vc < 507 + disp * 8) return 12'haaa;
        g = rom_val(20'(p.hc / 2 + (p.vc / 2) * IMG_W));
        return {g, g, g};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, want, cyc);
        end
    endtask

    task automatic model_edge(input pix_t p, input bit r, input bit up, input bit dn,
                              input bit cf, input bit cn);
        int j;
        bit cur_vb, prev_vb, rise;
        hist[cyc] = p;
        if (r) begin
            last_rst = cyc;
            m_sel = 0; m_lock = 0; m_mv = 0; m_disp = 0; m_cnt = 0; m_blink = 1;
            exp_out = '0;
        end else begin
            j = cyc - ROM_LAT;
            cur_vb = 0;
            prev_vb = 0;
            exp_out = '0;
            if (j > last_rst) begin
                cur_vb = hist[j].vb;
                exp_out = {11'(hist[j].hc), hist[j].hs, hist[j].hb, 11'(hist[j].vc),
                           hist[j].vs, hist[j].vb, render(hist[j], m_disp, m_blink)};
            end
            if (j - 1 > last_rst) prev_vb = hist[j-1].vb;
            rise = cur_vb && !prev_vb;
            if (m_lock) begin
                m_cnt = 0;
                m_blink = 1;
            end else if (rise) begin
                if (m_cnt == BF - 1) begin
                    m_cnt = 0;
                    m_blink = !m_blink;
                end else begin
                    m_cnt++;
                end
            end
            if (rise) m_disp = m_sel;
            m_mv = 0;
            if (!m_lock) begin
                if (cf) begin
                    m_lock = 1;
                    m_mv = 1;
                end else if (up && !dn) m_sel = (m_sel + N_ITEMS - 1) % N_ITEMS;
                else if (dn && !up) m_sel = (m_sel + 1) % N_ITEMS;
            end else if (cn) begin
                m_lock = 0;
            end
        end
        cyc++;
    endtask

    task automatic step(input int hc, input int vc, input bit hb, input bit vb, input bit r,
                        input bit up, input bit dn, input bit cf, input bit cn);
        pix_t p;
        logic [19:0] a_now;
        p.hc = hc; p.vc = vc; p.hb = hb; p.vb = vb;
        p.hs = 1'($urandom_range(0, 1));
        p.vs = 1'($urandom_range(0, 1));
        vga_in = {11'(hc), p.hs, hb, 11'(vc), p.vs, vb, 12'($urandom)};
        rst = r; sel_up = up; sel_down = dn; confirm = cf; cancel = cn;
        exp_addr = 20'(hc / 2 + (vc / 2) * IMG_W);
        @(negedge pclk);
        a_now = address;
        @(posedge pclk);
        model_edge(p, r, up, dn, cf, cn);
        for (int i = ROM_LAT - 1; i > 0; i--) rom_hist[i] = rom_hist[i-1];
        rom_hist[0] = a_now;
        #1;
        rom_pix = rom_val(rom_hist[ROM_LAT-1]);
    endtask

    task automatic idle(input bit up, input bit dn, input bit cf, input bit cn);
        step(0, 0, 1, 0, 0, up, dn, cf, cn);
    endtask

    task automatic vb_pulse();
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic show(input int hc, input int vc, input bit hb, input logic [11:0] want,
                        input string nm);
        step(hc, vc, hb, 0, 0, 0, 0, 0, 0);
        repeat (ROM_LAT) idle(0, 0, 0, 0);
        chk(nm, 64'(vga_out[11:0]), 64'(want));
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("vga_out", 64'(vga_out), 64'(exp_out));
            chk("selected", 64'(selected), 64'(m_sel));
            chk("locked", 64'(locked), 64'(m_lock));
            chk("mode_valid", 64'(mode_valid), 64'(m_mv));
            chk("address", 64'(address), 64'(exp_addr));
        end
    end

    initial begin
        for (int i = 0; i < ROM_LAT; i++) rom_hist[i] = '0;
        step(0, 0, 1, 0, 1, 0, 0, 0, 0);
        chk_en = 1;
        step(0, 0, 1, 0, 1, 0, 0, 1, 0);
        chk("rst_vga_out", 64'(vga_out), 64'd0);
        chk("rst_selected", 64'(selected), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_mode_valid", 64'(mode_valid), 64'd0);

        step(10, 6, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_10_6", 64'(address), 64'd1205);
        repeat (ROM_LAT) idle(0, 0, 0, 0);
        chk("lat_rgb", 64'(vga_out[11:0]), 64'h777);
        chk("lat_hcount", 64'(vga_out[37:27]), 64'd10);
        chk("lat_vcount", 64'(vga_out[24:14]), 64'd6);

        idle(0, 1, 0, 0); chk("sel_dn1", 64'(selected), 64'd1);
        idle(0, 1, 0, 0); chk("sel_dn2", 64'(selected), 64'd2);
        idle(0, 1, 0, 0); chk("sel_dn3", 64'(selected), 64'd3);
        idle(0, 1, 0, 0); chk("sel_wrap_dn", 64'(selected), 64'd0);
        idle(1, 0, 0, 0); chk("sel_wrap_up", 64'(selected), 64'd3);
        idle(1, 1, 0, 0); chk("sel_both", 64'(selected), 64'd3);
        idle(0, 1, 0, 0);
        idle(0, 1, 0, 0);
        idle(0, 1, 0, 0); chk("sel_two", 64'(selected), 64'd2);

        show(60, 501, 0, 12'haaa, "old_bar0");
        show(60, 517, 0, 12'hccc, "old_bar2_gray");
        vb_pulse();
        show(60, 517, 0, 12'haaa, "new_bar2");
        show(60, 501, 0, 12'h999, "new_bar0_gray");
        vb_pulse();
        show(60, 517, 0, 12'hccc, "hidden1");
        vb_pulse();
        show(60, 517, 0, 12'hccc, "hidden2");
        vb_pulse();
        show(60, 517, 0, 12'haaa, "visible_again");
        vb_pulse();
        vb_pulse();
        show(60, 517, 0, 12'hccc, "hidden_pre_lock");

        idle(0, 0, 1, 0);
        chk("confirm_mv", 64'(mode_valid), 64'd1);
        chk("confirm_locked", 64'(locked), 64'd1);
        idle(0, 0, 0, 0);
        chk("mv_one_cycle", 64'(mode_valid), 64'd0);
        show(60, 517, 0, 12'haaa, "locked_solid");
        idle(0, 1, 0, 0); chk("locked_ignores_dn", 64'(selected), 64'd2);
        idle(0, 0, 1, 0); chk("locked_ignores_cf", 64'(mode_valid), 64'd0);
        vb_pulse();
        vb_pulse();
        show(60, 517, 0, 12'haaa, "locked_solid2");
        idle(0, 0, 0, 1); chk("cancel_unlock", 64'(locked), 64'd0);
        vb_pulse();
        show(60, 517, 0, 12'haaa, "resume_vis");
        vb_pulse();
        show(60, 517, 0, 12'hccc, "resume_hidden");

`ifdef DRAW_MENU_DIAG_OVERLAY_EN
        show(250, 250, 0, 12'h0f0, "diag_250");
        show(250, 250, 1, 12'h000, "diag_hblnk");
`endif

        step(60, 517, 0, 0, 1, 0, 0, 1, 0);
        chk("midrst_vga_out", 64'(vga_out), 64'd0);
        chk("midrst_selected", 64'(selected), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            int hc, vc;
            hc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(40, 190)) : int'($urandom_range(0, 1023));
            vc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(490, 540)) : int'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0) vb_r = !vb_r;
            step(hc, vc, ($urandom_range(0, 7) == 0), vb_r, ($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0));
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
